// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared states and constants for the cache refill controller
package cache_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, HIT_RESP, MEM_REQ, MEM_WAIT, REFILL} state_t;
  localparam logic [3:0] WEN_FULL = 4'hF;
  localparam int DEF_TIMEOUT = 256;
endpackage

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: sequences CPU reads through cache lookup, memory refill and uncached bypass
module cache_refill_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  input  logic             cpu_uncached,
  output logic             cpu_ready,
  output logic             cpu_rvalid,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_err,
  output logic             cache_en_r,
  output logic [31:0]      cache_addr_r,
  input  logic             cache_miss,
  input  logic             cache_hit,
  input  logic [31:0]      cache_data_r,
  output logic             cache_refill,
  output logic             cache_en,
  output logic [31:0]      cache_addr_w,
  output logic [31:0]      cache_data_w,
  output logic [3:0]       cache_wen,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_err,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int TW = $clog2(TIMEOUT);
  state_t r_state, w_next;
  logic [31:0] r_req_addr, r_data;
  logic r_req_unc;
  logic [TW-1:0] r_timer;
  logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;
  logic w_accept, w_wait, w_timeout, w_mem_ok, w_mem_fail, w_unc_ok, w_hit_resp;
  logic w_unused;
  // The registered hit flag is redundant: a hit is already decided by cache_miss at lookup.
  assign w_unused = cache_hit;
  assign cpu_ready = r_state == IDLE || r_state == HIT_RESP;
  assign w_accept = cpu_req && cpu_ready;
  assign w_wait = r_state == MEM_WAIT;
  assign w_hit_resp = r_state == HIT_RESP;
  assign w_timeout = r_timer == TW'(TIMEOUT - 1);
  assign w_mem_ok = w_wait && mem_rvalid && !mem_err;
  assign w_mem_fail = w_wait && (mem_rvalid ? mem_err : w_timeout);
  assign w_unc_ok = w_mem_ok && r_req_unc;
  assign cache_en_r = w_accept && !cpu_uncached;
  assign cache_addr_r = cache_en_r ? cpu_addr : '0;
  assign mem_req = r_state == MEM_REQ;
  assign mem_addr = mem_req ? r_req_addr : '0;
  assign cache_refill = r_state == REFILL;
  assign cache_en = cache_refill;
  assign cache_wen = cache_refill ? WEN_FULL : '0;
  assign cache_addr_w = cache_refill ? r_req_addr : '0;
  assign cache_data_w = cache_refill ? r_data : '0;
  assign cpu_rvalid = w_hit_resp || cache_refill || w_unc_ok || w_mem_fail;
  assign cpu_err = w_mem_fail;
  assign cpu_rdata = w_hit_resp ? cache_data_r : cache_refill ? r_data : w_unc_ok ? mem_rdata : '0;
  assign hit_cnt = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, HIT_RESP: w_next = !w_accept ? IDLE : (cpu_uncached || cache_miss) ? MEM_REQ : HIT_RESP;
      MEM_REQ:        w_next = mem_gnt ? MEM_WAIT : MEM_REQ;
      MEM_WAIT:       w_next = w_mem_ok && !r_req_unc ? REFILL : (w_unc_ok || w_mem_fail) ? IDLE : MEM_WAIT;
      REFILL:         w_next = IDLE;
      default:        w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_req_addr <= '0;
      r_req_unc <= 1'b0;
      r_data <= '0;
      r_timer <= '0;
      r_hit_cnt <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_req_addr <= cpu_addr;
        r_req_unc <= cpu_uncached;
      end
      if (cache_en_r && cache_miss) r_miss_cnt <= r_miss_cnt + 1'b1;
      if (cache_en_r && !cache_miss) r_hit_cnt <= r_hit_cnt + 1'b1;
      if (mem_req && mem_gnt) r_timer <= '0;
      else if (w_wait) r_timer <= r_timer + 1'b1;
      if (w_mem_ok) r_data <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed checks of hits, refills, uncached reads, errors and timeout
module tb_cache_refill_ctrl;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic reset, cpu_req, cpu_uncached, cache_miss, cache_hit, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] cpu_addr, cache_data_r, mem_rdata;
  logic cpu_ready, cpu_rvalid, cpu_err, cache_en_r, cache_refill, cache_en, mem_req;
  logic [31:0] cpu_rdata, cache_addr_r, cache_addr_w, cache_data_w, mem_addr;
  logic [3:0] cache_wen;
  logic [31:0] hit_cnt, miss_cnt;
  int errors = 0, checks = 0;

  cache_refill_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_uncached(cpu_uncached),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .cache_en_r(cache_en_r), .cache_addr_r(cache_addr_r), .cache_miss(cache_miss), .cache_hit(cache_hit),
    .cache_data_r(cache_data_r), .cache_refill(cache_refill), .cache_en(cache_en),
    .cache_addr_w(cache_addr_w), .cache_data_w(cache_data_w), .cache_wen(cache_wen),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; cpu_req = 0; cpu_addr = 0; cpu_uncached = 0; cache_miss = 0; cache_hit = 0;
    cache_data_r = 0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = 0;
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_ready", cpu_ready, 1);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_strobes", {mem_req, cache_refill, cache_en, cache_en_r, cache_wen}, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_miss", miss_cnt, 0);

    cpu_req = 1; cpu_addr = 32'h40; cache_miss = 1; #1;
    chk("miss_lookup_en", cache_en_r, 1);
    chk("miss_lookup_addr", cache_addr_r, 32'h40);
    tick(); cpu_req = 0; cache_miss = 0; #1;
    chk("miss_memreq", mem_req, 1);
    chk("miss_memaddr", mem_addr, 32'h40);
    chk("miss_busy", cpu_ready, 0);
    chk("miss_cnt1", miss_cnt, 1);
    tick();
    chk("miss_memreq_held", mem_req, 1);
    mem_gnt = 1;
    tick(); mem_gnt = 0; #1;
    chk("miss_gnt_drop", mem_req, 0);
    tick();
    chk("miss_wait_rv", cpu_rvalid, 0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
    chk("miss_no_early_rv", cpu_rvalid, 0);
    tick(); mem_rvalid = 0; mem_rdata = 0; #1;
    chk("refill_strobe", {cache_refill, cache_en}, 2'b11);
    chk("refill_wen", cache_wen, 4'hF);
    chk("refill_addr", cache_addr_w, 32'h40);
    chk("refill_data", cache_data_w, 32'hDEADBEEF);
    chk("refill_rvalid", {cpu_rvalid, cpu_err}, 2'b10);
    chk("refill_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("refill_no_lookup", cache_en_r, 0);
    tick();
    chk("post_refill_idle", {cpu_ready, cpu_rvalid, cache_refill}, 3'b100);

    cpu_req = 1; cpu_addr = 32'h40; #1;
    chk("hit_lookup_en", cache_en_r, 1);
    tick(); cpu_req = 0; cache_data_r = 32'hDEADBEEF; #1;
    chk("hit_rvalid", {cpu_rvalid, cpu_err}, 2'b10);
    chk("hit_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("hit_cnt1", hit_cnt, 1);
    chk("hit_no_memreq", mem_req, 0);
    tick();
    chk("hit_pulse_end", cpu_rvalid, 0);

    cpu_req = 1; cpu_addr = 32'h40;
    tick();
    for (int i = 1; i <= 4; i++) begin
      cache_data_r = 32'hA000_0000 + 32'(i - 1);
      cpu_req = (i < 4); cpu_addr = 32'h40 + 32'(i); #1;
      chk($sformatf("b2b_rvalid%0d", i), cpu_rvalid, 1);
      chk($sformatf("b2b_rdata%0d", i), cpu_rdata, 32'hA000_0000 + 32'(i - 1));
      chk($sformatf("b2b_ready%0d", i), cpu_ready, 1);
      tick();
    end
    chk("b2b_end", cpu_rvalid, 0);
    chk("b2b_hits", hit_cnt, 5);

    cpu_req = 1; cpu_addr = 32'h1FC0_0000; cpu_uncached = 1; cache_miss = 1; #1;
    chk("unc_no_lookup", cache_en_r, 0);
    tick(); cpu_req = 0; cpu_uncached = 0; cache_miss = 0; #1;
    chk("unc_memreq", mem_req, 1);
    chk("unc_memaddr", mem_addr, 32'h1FC0_0000);
    mem_gnt = 1;
    tick(); mem_gnt = 0;
    mem_rvalid = 1; mem_rdata = 32'h1234_5678; #1;
    chk("unc_rvalid", {cpu_rvalid, cpu_err}, 2'b10);
    chk("unc_rdata", cpu_rdata, 32'h1234_5678);
    chk("unc_no_refill", cache_refill, 0);
    tick(); mem_rvalid = 0; #1;
    chk("unc_idle", {cpu_ready, cpu_rvalid, cache_refill}, 3'b100);
    chk("unc_counters", {hit_cnt[15:0], miss_cnt[15:0]}, {16'd5, 16'd1});

    cpu_req = 1; cpu_addr = 32'h80; cache_miss = 1;
    tick(); cpu_req = 0; cache_miss = 0; mem_gnt = 1;
    tick(); mem_gnt = 0;
    mem_rvalid = 1; mem_err = 1; mem_rdata = 32'hBAD0_BAD0; #1;
    chk("err_rvalid", {cpu_rvalid, cpu_err}, 2'b11);
    chk("err_rdata", cpu_rdata, 0);
    tick(); mem_rvalid = 0; mem_err = 0; #1;
    chk("err_no_refill", {cache_refill, cpu_rvalid}, 0);
    chk("err_ready", cpu_ready, 1);
    chk("err_miss_cnt", miss_cnt, 2);

    cpu_req = 1; cpu_addr = 32'h100; cpu_uncached = 1;
    tick(); cpu_req = 0; cpu_uncached = 0; mem_gnt = 1;
    tick(); mem_gnt = 0; #1;
    for (int i = 0; i < TO - 1; i++) begin
      chk($sformatf("to_wait%0d", i), cpu_rvalid, 0);
      tick();
    end
    chk("to_rvalid", {cpu_rvalid, cpu_err}, 2'b11);
    chk("to_rdata", cpu_rdata, 0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA; #1;
    chk("late_rvalid_ignored", {cpu_rvalid, cpu_ready}, 2'b01);
    tick(); mem_rvalid = 0; #1;
    chk("late_no_refill", cache_refill, 0);

    cpu_req = 1; cpu_addr = 32'h40;
    tick(); cpu_req = 0; cache_data_r = 32'hDEADBEEF; #1;
    chk("after_to_hit", {cpu_rvalid, cpu_err}, 2'b10);
    chk("after_to_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("after_to_hits", hit_cnt, 6);
    tick();

    cpu_req = 1; cpu_addr = 32'h200; cache_miss = 1;
    tick(); cpu_req = 0; cache_miss = 0; reset = 1;
    tick(); reset = 0; #1;
    chk("midrst_idle", {mem_req, cpu_ready, cpu_rvalid, cache_refill}, 4'b0100);
    chk("midrst_counters", {hit_cnt[15:0], miss_cnt[15:0]}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
